// File: rtl/i2c_target_regs.sv
// I2C target with a pointer-addressed register file. SCL/SDA are oversampled
// on clk_i; SDA is only ever pulled low and SCL is never stretched.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NREGS       = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_oen_o,
    output logic          wr_stb_o,
    output logic [PW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          busy_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WR_ACK, READ, RACK, IDLE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_q, sda_q;

    // Synchronizers reset to the idle-bus level so no edge is seen out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_s, sda_s, start, stop, scl_rise, scl_fall;
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign start    = scl_s && scl_q && sda_q && !sda_s;
    assign stop     = scl_s && scl_q && !sda_q && sda_s;
    assign scl_rise = scl_s && !scl_q;
    assign scl_fall = !scl_s && scl_q;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg, tx;
    logic          rw, ack_drv;
    logic [PW-1:0] ptr;
    logic [7:0]    regs [NREGS];

    logic [7:0]    rx_byte;
    logic [PW-1:0] ptr_nxt;
    assign rx_byte = {shreg[6:0], sda_s};
    assign ptr_nxt = ptr + PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            ack_drv   <= 1'b0;
            ptr       <= '0;
            sda_o     <= 1'b1;
            sda_oen_o <= 1'b1;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            busy_o    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            wr_stb_o <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                sda_o     <= 1'b1;
                sda_oen_o <= 1'b1;
                busy_o    <= 1'b0;
            end else if (start) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_o     <= 1'b1;
                sda_oen_o <= 1'b1;
            end else begin
                case (state)
                    ADDR, PTR, WRITE: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            ack_drv <= 1'b0;
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    state  <= ADDR_ACK;
                                    rw     <= rx_byte[0];
                                    busy_o <= 1'b1;
                                end else begin
                                    state  <= IDLE;
                                    busy_o <= 1'b0;
                                end
                            end else if (state == PTR) begin
                                ptr   <= rx_byte[PW-1:0];
                                state <= PTR_ACK;
                            end else begin
                                state <= WR_ACK;
                            end
                        end
                    end
                    // First fall drives the ACK low, second fall releases it.
                    ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
                        if (!ack_drv) begin
                            ack_drv   <= 1'b1;
                            sda_o     <= 1'b0;
                            sda_oen_o <= 1'b0;
                            if (state == WR_ACK) begin
                                regs[ptr] <= shreg;
                                wr_stb_o  <= 1'b1;
                                wr_addr_o <= ptr;
                                wr_data_o <= shreg;
                                ptr       <= ptr_nxt;
                            end
                        end else begin
                            sda_o     <= 1'b1;
                            sda_oen_o <= 1'b1;
                            state     <= WRITE;
                            if (state == ADDR_ACK) begin
                                if (rw) begin
                                    // The ACK-release fall also presents the first read bit.
                                    sda_o     <= regs[ptr][7];
                                    sda_oen_o <= regs[ptr][7];
                                    tx        <= {regs[ptr][6:0], 1'b0};
                                    bit_cnt   <= 4'd1;
                                    state     <= READ;
                                end else begin
                                    state <= PTR;
                                end
                            end
                        end
                    end
                    READ: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_o     <= 1'b1;
                            sda_oen_o <= 1'b1;
                            state     <= RACK;
                        end else begin
                            sda_o     <= tx[7];
                            sda_oen_o <= tx[7];
                            tx        <= {tx[6:0], 1'b0};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                    RACK: if (scl_rise) begin
                        if (!sda_s) begin
                            ptr     <= ptr_nxt;
                            tx      <= regs[ptr_nxt];
                            bit_cnt <= '0;
                            state   <= READ;
                        end else begin
                            state  <= IDLE_WAIT;
                            busy_o <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged bus master on a wired-AND SDA, with
// a register-array/pointer reference model of the target.
module tb_i2c_target_regs;

    localparam int NREGS = 16;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_scl = 1'b1, m_sda = 1'b1;
    logic          sda_bus;
    logic          sda_o, sda_oen_o, wr_stb_o, busy_o;
    logic [PW-1:0] wr_addr_o;
    logic [7:0]    wr_data_o;

    assign sda_bus = m_sda & (sda_oen_o | sda_o);

    i2c_target_regs dut (
        .clk_i(clk), .rst_i(rst), .scl_i(m_scl), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_oen_o(sda_oen_o), .wr_stb_o(wr_stb_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0;
    logic [7:0]  model [NREGS];
    int          ptr_m = 0;
    logic [11:0] exp_w [$];
    logic [11:0] wlog [$];
    int          oen_low_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (wr_stb_o === 1'b1) wlog.push_back({wr_addr_o, wr_data_o});
        if (sda_oen_o === 1'b0) oen_low_cnt++;
        if (busy_o === 1'b1) busy_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        clks(2); m_sda = 1'b1; clks(6); m_scl = 1'b1; clks(8);
        m_sda = 1'b0; clks(8); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        clks(2); m_sda = 1'b0; clks(6); m_scl = 1'b1; clks(8);
        m_sda = 1'b1; clks(8);
    endtask

    task automatic put_bit(input logic b);
        clks(2); m_sda = b; clks(6); m_scl = 1'b1; clks(8); m_scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        clks(2); m_sda = 1'b1; clks(6); m_scl = 1'b1; clks(4);
        @(negedge clk); b = sda_bus; clks(4); m_scl = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = !b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin get_bit(b); d[i] = b; end
        put_bit(!ack);
    endtask

    // Full write transaction; the model absorbs the bytes as the target should.
    task automatic do_write(input int p, input logic [7:0] data [16], input int n, output int acks);
        logic a;
        acks = 0;
        bus_start();
        put_byte(8'hA0, a); acks += int'(a);
        put_byte(8'(p), a); acks += int'(a);
        ptr_m = p % NREGS;
        for (int i = 0; i < n; i++) begin
            put_byte(data[i], a); acks += int'(a);
            model[ptr_m] = data[i];
            exp_w.push_back({4'(ptr_m), data[i]});
            ptr_m = (ptr_m + 1) % NREGS;
        end
        bus_stop();
    endtask

    task automatic do_read(input int p, input bit set_ptr, input int n,
                           output logic [7:0] got [16], output int acks);
        logic a;
        logic [7:0] d;
        acks = 0;
        bus_start();
        if (set_ptr) begin
            put_byte(8'hA0, a); acks += int'(a);
            put_byte(8'(p), a); acks += int'(a);
            bus_start();
        end
        put_byte(8'hA1, a); acks += int'(a);
        for (int i = 0; i < n; i++) begin get_byte(d, i != n - 1); got[i] = d; end
        bus_stop();
    endtask

    task automatic test_reset();
        rst = 1'b1; clks(3); @(negedge clk);
        n_vec++; if (sda_oen_o !== 1'b1) begin n_err++; $display("FAIL reset_oen: got %b want 1", sda_oen_o); end
        n_vec++; if (sda_o !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1", sda_o); end
        n_vec++; if (wr_stb_o !== 1'b0) begin n_err++; $display("FAIL reset_stb: got %b want 0", wr_stb_o); end
        n_vec++; if (wr_addr_o !== 4'h0) begin n_err++; $display("FAIL reset_waddr: got %h want 0", wr_addr_o); end
        n_vec++; if (wr_data_o !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %h want 00", wr_data_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        rst = 1'b0; clks(4);
        for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
        ptr_m = 0;
    endtask

    task automatic test_burst_write();
        logic a0, a1, a2, a3;
        int wb;
        wb = wlog.size();
        bus_start();
        put_byte(8'hA0, a0); put_byte(8'h03, a1); put_byte(8'hA5, a2); put_byte(8'h5A, a3);
        @(negedge clk);
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL bw_busy_before_stop: got %b want 1", busy_o); end
        bus_stop(); @(negedge clk);
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL bw_busy_after_stop: got %b want 0", busy_o); end
        n_vec++; if ({a0, a1, a2, a3} !== 4'hF) begin n_err++; $display("FAIL bw_acks: got %b want 1111", {a0, a1, a2, a3}); end
        n_vec++; if (wlog.size() - wb !== 2) begin n_err++; $display("FAIL bw_stb_count: got %0d want 2", wlog.size() - wb); end
        if (wlog.size() - wb == 2) begin
            n_vec++; if (wlog[wb] !== 12'h3A5) begin n_err++; $display("FAIL bw_stb0: got %h want 3a5", wlog[wb]); end
            n_vec++; if (wlog[wb+1] !== 12'h45A) begin n_err++; $display("FAIL bw_stb1: got %h want 45a", wlog[wb+1]); end
        end
        model[3] = 8'hA5; model[4] = 8'h5A; ptr_m = 5;
        exp_w.push_back(12'h3A5); exp_w.push_back(12'h45A);
    endtask

    task automatic test_ptr_read();
        logic [7:0] got [16];
        int acks, wb;
        wb = wlog.size();
        do_read(3, 1'b1, 2, got, acks);
        n_vec++; if (acks !== 3) begin n_err++; $display("FAIL pr_acks: got %0d want 3", acks); end
        n_vec++; if (got[0] !== 8'hA5) begin n_err++; $display("FAIL pr_byte0: got %h want a5", got[0]); end
        n_vec++; if (got[1] !== 8'h5A) begin n_err++; $display("FAIL pr_byte1: got %h want 5a", got[1]); end
        n_vec++; if (wlog.size() !== wb) begin n_err++; $display("FAIL pr_no_stb: got %0d want %0d", wlog.size(), wb); end
        ptr_m = 4;
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int o, b;
        o = oen_low_cnt; b = busy_cnt;
        bus_start(); put_byte(8'hA2, a0); put_byte(8'h00, a1); bus_stop();
        n_vec++; if (a0 !== 1'b0) begin n_err++; $display("FAIL wa_addr_nack: got ack=%b want 0", a0); end
        n_vec++; if (a1 !== 1'b0) begin n_err++; $display("FAIL wa_data_nack: got ack=%b want 0", a1); end
        n_vec++; if (oen_low_cnt !== o) begin n_err++; $display("FAIL wa_oen_released: got %0d low cycles want 0", oen_low_cnt - o); end
        n_vec++; if (busy_cnt !== b) begin n_err++; $display("FAIL wa_busy_low: got %0d busy cycles want 0", busy_cnt - b); end
    endtask

    task automatic test_wrap();
        logic [7:0] d [16];
        logic [7:0] got [16];
        int acks, wb;
        wb = wlog.size();
        d[0] = 8'h11; d[1] = 8'h22;
        do_write(8'h0F, d, 2, acks);
        n_vec++; if (acks !== 4) begin n_err++; $display("FAIL wrap_acks: got %0d want 4", acks); end
        n_vec++; if (wlog.size() - wb !== 2) begin n_err++; $display("FAIL wrap_stb_count: got %0d want 2", wlog.size() - wb); end
        if (wlog.size() - wb == 2) begin
            n_vec++; if (wlog[wb] !== 12'hF11) begin n_err++; $display("FAIL wrap_stb0: got %h want f11", wlog[wb]); end
            n_vec++; if (wlog[wb+1] !== 12'h022) begin n_err++; $display("FAIL wrap_stb1: got %h want 022", wlog[wb+1]); end
        end
        do_read(8'h0F, 1'b1, 2, got, acks);
        n_vec++; if (got[0] !== 8'h11) begin n_err++; $display("FAIL wrap_rd15: got %h want 11", got[0]); end
        n_vec++; if (got[1] !== 8'h22) begin n_err++; $display("FAIL wrap_rd0: got %h want 22", got[1]); end
        ptr_m = 0;
    endtask

    task automatic test_aborted();
        logic [7:0] old;
        logic [7:0] got [16];
        logic a0, a1;
        int acks, wb;
        old = model[5]; wb = wlog.size();
        bus_start(); put_byte(8'hA0, a0); put_byte(8'h05, a1);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        bus_stop();
        n_vec++; if (wlog.size() !== wb) begin n_err++; $display("FAIL ab_no_stb: got %0d want 0", wlog.size() - wb); end
        do_read(5, 1'b1, 1, got, acks);
        n_vec++; if (got[0] !== old) begin n_err++; $display("FAIL ab_reg5: got %h want %h", got[0], old); end
        ptr_m = 5;
    endtask

    task automatic test_random();
        logic [7:0] d [16];
        logic [7:0] got [16];
        int acks, p, n, st, wb;
        bit sp;
        for (int it = 0; it < 14; it++) begin
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0) begin
                wb = exp_w.size();
                p = $urandom_range(0, 255);
                for (int i = 0; i < n; i++) d[i] = 8'($urandom);
                do_write(p, d, n, acks);
                n_vec++; if (acks !== n + 2) begin n_err++; $display("FAIL rnd_wr_acks: got %0d want %0d", acks, n + 2); end
                n_vec++; if (wlog.size() !== exp_w.size()) begin n_err++; $display("FAIL rnd_stb_count: got %0d want %0d", wlog.size(), exp_w.size()); end
                for (int i = wb; i < exp_w.size() && i < wlog.size(); i++) begin
                    n_vec++; if (wlog[i] !== exp_w[i]) begin n_err++; $display("FAIL rnd_stb: got %h want %h", wlog[i], exp_w[i]); end
                end
            end else begin
                sp = ($urandom_range(0, 1) == 1);
                p  = $urandom_range(0, 255);
                st = sp ? p % NREGS : ptr_m;
                do_read(p, sp, n, got, acks);
                n_vec++; if (acks !== (sp ? 3 : 1)) begin n_err++; $display("FAIL rnd_rd_acks: got %0d want %0d", acks, sp ? 3 : 1); end
                for (int i = 0; i < n; i++) begin
                    n_vec++; if (got[i] !== model[(st + i) % NREGS]) begin
                        n_err++; $display("FAIL rnd_rd reg%0d: got %h want %h", (st + i) % NREGS, got[i], model[(st + i) % NREGS]);
                    end
                end
                ptr_m = (st + n - 1) % NREGS;
            end
        end
        do_read(0, 1'b1, NREGS, got, acks);
        for (int i = 0; i < NREGS; i++) begin
            n_vec++; if (got[i] !== model[i]) begin n_err++; $display("FAIL dump reg%0d: got %h want %h", i, got[i], model[i]); end
        end
        ptr_m = NREGS - 1;
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d [16];
        logic [7:0] got [16];
        logic a;
        int acks;
        bit seen;
        d[0] = 8'h3C;
        do_write(2, d, 1, acks);
        bus_start(); put_byte(8'hA0, a); put_byte(8'h02, a); bus_start(); put_byte(8'hA1, a);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (sda_oen_o === 1'b0) seen = 1'b1;
        end
        n_vec++; if (sda_oen_o !== 1'b0) begin n_err++; $display("FAIL rr_driving_zero: got oen=%b want 0", sda_oen_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (sda_oen_o !== 1'b1) begin n_err++; $display("FAIL rr_release: got oen=%b want 1", sda_oen_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rr_busy: got %b want 0", busy_o); end
        clks(2); rst = 1'b0;
        m_sda = 1'b1; m_scl = 1'b1; clks(10);
        for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
        ptr_m = 0;
        do_read(0, 1'b1, NREGS, got, acks);
        for (int i = 0; i < NREGS; i++) begin
            n_vec++; if (got[i] !== 8'h00) begin n_err++; $display("FAIL rr_cleared reg%0d: got %h want 00", i, got[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_burst_write();
        test_ptr_read();
        test_wrong_addr();
        test_wrap();
        test_aborted();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
